// File: rtl/floppy_stepper.sv
// Step/direction generator for one floppy drive: homes the head to track 0 after
// reset, then bounces it between 0 and MAX_TRACK at the requested step period.
module floppy_stepper #(
  parameter int SP_WIDTH    = 22,
  parameter int MAX_TRACK   = 79,
  parameter int PULSE_LEN   = 16,
  parameter int HOME_PERIOD = 150000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SP_WIDTH-1:0] setpoint,
  input  logic                enable,
  output logic                step_n,
  output logic                dir,
  output logic [6:0]          track,
  output logic                home_done
);
  localparam int HW = $clog2(HOME_PERIOD + 1);
  localparam int PW = $clog2(PULSE_LEN + 1);
  localparam logic [6:0]        MAX_T     = 7'(MAX_TRACK);
  localparam logic [SP_WIDTH:0] PULSE_EXT = (SP_WIDTH + 1)'(PULSE_LEN);
  localparam logic [SP_WIDTH:0] ONE_EXT   = (SP_WIDTH + 1)'(1);

  typedef enum logic [1:0] {HOME, IDLE, PLAY} state_t;

  state_t              state, state_next;
  logic [SP_WIDTH-1:0] cnt, cnt_next;
  logic [HW-1:0]       hcnt, hcnt_next;
  logic [7:0]          home_left, home_left_next;
  logic [PW-1:0]       pcnt, pcnt_next;
  logic                fire, fire_next;
  logic                step_n_next, dir_next, home_done_next;
  logic [6:0]          track_next;
  logic                sp_valid, play_ok, period_end, pulse_end, launch;

  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    hcnt_next      = hcnt;
    home_left_next = home_left;
    pcnt_next      = pcnt;
    fire_next      = 1'b0;
    step_n_next    = step_n;
    dir_next       = dir;
    track_next     = track;
    home_done_next = home_done;
    launch         = 1'b0;

    sp_valid   = {1'b0, setpoint} > PULSE_EXT;
    play_ok    = enable && sp_valid;
    // Widened compare so setpoint-1 never underflows.
    period_end = ({1'b0, cnt} + ONE_EXT) >= {1'b0, setpoint};
    pulse_end  = !step_n && (pcnt == '0);

    case (state)
      HOME: begin
        if (home_left != 8'd0) begin
          if (hcnt == HW'(HOME_PERIOD - 1)) begin
            hcnt_next      = '0;
            launch         = 1'b1;
            home_left_next = home_left - 8'd1;
          end else begin
            hcnt_next = hcnt + HW'(1);
          end
        end else if (pulse_end) begin
          state_next     = IDLE;
          home_done_next = 1'b1;
          dir_next       = 1'b1;
        end
      end
      IDLE: begin
        cnt_next = '0;
        if (play_ok) state_next = PLAY;
      end
      PLAY: begin
        if (!play_ok) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (period_end) begin
          cnt_next  = '0;
          fire_next = 1'b1;
        end else begin
          cnt_next = cnt + SP_WIDTH'(1);
        end
      end
      default: state_next = HOME;
    endcase

    // A period end registers into fire, so the pulse falls one edge later.
    if (fire) launch = 1'b1;

    if (launch) begin
      step_n_next = 1'b0;
      pcnt_next   = PW'(PULSE_LEN - 1);
      if (dir) track_next = (track == MAX_T) ? track : track + 7'd1;
      else     track_next = (track == 7'd0)  ? track : track - 7'd1;
    end else if (pulse_end) begin
      step_n_next = 1'b1;
      if (home_done) begin
        if (track == MAX_T)     dir_next = 1'b0;
        else if (track == 7'd0) dir_next = 1'b1;
      end
    end else if (!step_n) begin
      pcnt_next = pcnt - PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HOME;
      cnt       <= '0;
      hcnt      <= '0;
      home_left <= 8'(MAX_TRACK + 1);
      pcnt      <= '0;
      fire      <= 1'b0;
      step_n    <= 1'b1;
      dir       <= 1'b0;
      track     <= MAX_T;
      home_done <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      hcnt      <= hcnt_next;
      home_left <= home_left_next;
      pcnt      <= pcnt_next;
      fire      <= fire_next;
      step_n    <= step_n_next;
      dir       <= dir_next;
      track     <= track_next;
      home_done <= home_done_next;
    end
  end
endmodule

// File: tb/tb_floppy_stepper.sv
// Bench for floppy_stepper: edge-timestamp reference model checked every cycle,
// plus literal timing/track expectations for homing, tone, bounce, shrink, stop and reset.
module tb_floppy_stepper;
  localparam int SPW = 22;
  localparam int MT  = 7;
  localparam int PL  = 4;
  localparam int HP  = 20;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           enable = 1'b0;
  logic [SPW-1:0] setpoint = '0;
  logic           step_n, dir, home_done;
  logic [6:0]     track;

  floppy_stepper #(.SP_WIDTH(SPW), .MAX_TRACK(MT), .PULSE_LEN(PL), .HOME_PERIOD(HP)) dut (
    .clk(clk), .rst(rst), .setpoint(setpoint), .enable(enable),
    .step_n(step_n), .dir(dir), .track(track), .home_done(home_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int t = 0;

  // Reference model: absolute edge timestamps for pulses, homing and the period.
  bit m_homing, m_play, m_step, m_dir, m_hd;
  int m_track, m_left, m_next_home, m_low_until, m_anchor, m_pending;
  logic [6:0] exp_q[$];

  // Observations of the DUT.
  int falls_tq[$];
  int falls_trk[$];
  int nfalls = 0;
  int fall_t = -1;
  int rise_t = -1;
  int hd_rise_t = -1;
  logic prev_step = 1'b1;
  logic prev_hd = 1'b0;

  task automatic model_step(input bit r, input bit en, input int sp);
    bit launch, rise, ok;
    t++;
    if (r) begin
      m_homing = 1; m_play = 0; m_step = 1; m_dir = 0; m_hd = 0;
      m_track = MT; m_left = MT + 1; m_next_home = t + HP;
      m_low_until = -1; m_pending = -1;
      exp_q.delete();
      return;
    end
    ok     = en && (sp > PL);
    launch = (t == m_pending) || (m_homing && m_left > 0 && t == m_next_home);
    rise   = !m_step && (t == m_low_until);
    if (launch) begin
      m_step = 0;
      m_low_until = t + PL;
      if (m_dir) m_track = (m_track < MT) ? m_track + 1 : MT;
      else       m_track = (m_track > 0) ? m_track - 1 : 0;
      exp_q.push_back(7'(m_track));
    end else if (rise) begin
      m_step = 1;
      if (m_hd && m_track == MT) m_dir = 0;
      else if (m_hd && m_track == 0) m_dir = 1;
    end
    if (m_homing) begin
      if (m_left > 0 && t == m_next_home) begin
        m_left--;
        m_next_home += HP;
      end else if (m_left == 0 && rise) begin
        m_homing = 0; m_hd = 1; m_dir = 1;
      end
    end else if (!m_play) begin
      if (ok) begin m_play = 1; m_anchor = t; end
    end else if (!ok) begin
      m_play = 0;
    end else if (t - 1 - m_anchor >= sp - 1) begin
      m_anchor = t;
      m_pending = t + 1;
    end
  endtask

  task automatic tick();
    logic [6:0] e;
    model_step(rst, enable, int'(setpoint));
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (step_n !== m_step || dir !== m_dir || track !== 7'(m_track) || home_done !== m_hd) begin
      fails++;
      $display("FAIL cycle t=%0d: got step_n=%b dir=%b track=%0d home_done=%b, expected %b %b %0d %b",
               t, step_n, dir, track, home_done, m_step, m_dir, m_track, m_hd);
    end
    if (prev_step === 1'b1 && step_n === 1'b0) begin
      fall_t = t;
      nfalls++;
      falls_tq.push_back(t);
      falls_trk.push_back(int'(track));
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL fall_track t=%0d: unexpected fall with track=%0d", t, track);
      end else begin
        e = exp_q.pop_front();
        if (track !== e) begin
          fails++;
          $display("FAIL fall_track t=%0d: got %0d, expected %0d", t, track, e);
        end
      end
    end
    if (prev_step === 1'b0 && step_n === 1'b1) rise_t = t;
    if (prev_hd === 1'b0 && home_done === 1'b1) hd_rise_t = t;
    prev_step = step_n;
    prev_hd = home_done;
  endtask

  task automatic check(input string name, input int got, input int exp_v);
    tests++;
    if (got !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp_v);
    end
  endtask

  task automatic wait_fall(input int max_c);
    int n0;
    int c;
    n0 = nfalls;
    c = 0;
    while (nfalls == n0 && c < max_c) begin
      tick();
      c++;
    end
    tests++;
    if (nfalls == n0) begin
      fails++;
      $display("FAIL wait_fall: no step_n fall within %0d cycles", max_c);
    end
  endtask

  task automatic clear_obs();
    falls_tq.delete();
    falls_trk.delete();
  endtask

  int rel, e_edge, f0;
  int bounce_exp[16] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};

  initial begin
    rst = 1'b1; enable = 1'b1; setpoint = SPW'(10);
    repeat (3) tick();
    check("reset_step_n", int'(step_n), 1);
    check("reset_track", int'(track), MT);
    check("reset_home_done", int'(home_done), 0);
    check("reset_dir", int'(dir), 0);

    // Homing with enable held high; setpoint left silent for afterwards.
    rel = t;
    rst = 1'b0;
    setpoint = SPW'(PL);
    clear_obs();
    repeat (170) tick();
    check("home_pulse_count", falls_tq.size(), MT + 1);
    if (falls_tq.size() == MT + 1) begin
      check("home_first_fall", falls_tq[0] - rel, HP);
      check("home_spacing", falls_tq[MT] - falls_tq[0], MT * HP);
      check("home_last_track", falls_trk[MT], 0);
    end
    check("home_done_edge", hd_rise_t - rel, (MT + 1) * HP + PL);
    check("home_dir_after", int'(dir), 1);

    // Silent setpoint keeps the head still.
    clear_obs();
    repeat (30) tick();
    check("silent_no_pulses", falls_tq.size(), 0);
    check("silent_track", int'(track), 0);

    // Steady tone, then let it bounce.
    setpoint = SPW'(10);
    e_edge = t + 1;
    clear_obs();
    repeat (162) tick();
    check("tone_fall_count", falls_tq.size(), 16);
    if (falls_tq.size() >= 3) begin
      check("tone_fall1", falls_tq[0] - e_edge, 11);
      check("tone_fall2", falls_tq[1] - e_edge, 21);
      check("tone_fall3", falls_tq[2] - e_edge, 31);
    end
    if (falls_trk.size() >= 16)
      for (int i = 0; i < 16; i++) check($sformatf("bounce_track%0d", i), falls_trk[i], bounce_exp[i]);

    // Setpoint shrink from 100 to 10 while the period counter sits at 50.
    setpoint = SPW'(100);
    wait_fall(300);
    f0 = fall_t;
    repeat (49) tick();
    setpoint = SPW'(10);
    clear_obs();
    repeat (25) tick();
    check("shrink_count", falls_tq.size() >= 2 ? 1 : 0, 1);
    if (falls_tq.size() >= 2) begin
      check("shrink_fall", falls_tq[0] - f0, 51);
      check("shrink_period", falls_tq[1] - falls_tq[0], 10);
    end

    // Drop enable right after a fall: that pulse completes, nothing follows.
    wait_fall(40);
    enable = 1'b0;
    f0 = fall_t;
    clear_obs();
    repeat (40) tick();
    check("stop_pulse_len", rise_t - f0, PL);
    check("stop_no_more", falls_tq.size(), 0);

    // Randomised operation with occasional resets.
    for (int i = 0; i < 40; i++) begin
      enable = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       setpoint = SPW'($urandom_range(0, PL));
        1, 2:    setpoint = SPW'($urandom_range(PL + 1, 30));
        default: setpoint = SPW'($urandom_range(31, 200));
      endcase
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      repeat ($urandom_range(1, 120)) tick();
    end

    // Reset while step_n is low.
    enable = 1'b1;
    setpoint = SPW'(10);
    begin
      int c;
      c = 0;
      while (home_done !== 1'b1 && c < 400) begin tick(); c++; end
      check("rand_home_done", int'(home_done), 1);
    end
    wait_fall(40);
    rst = 1'b1;
    tick();
    check("midrst_step_n", int'(step_n), 1);
    check("midrst_track", int'(track), MT);
    check("midrst_home_done", int'(home_done), 0);
    check("midrst_dir", int'(dir), 0);
    rel = t;
    rst = 1'b0;
    hd_rise_t = -1;
    clear_obs();
    repeat (170) tick();
    check("rehome_pulses", falls_tq.size() >= MT + 1 ? 1 : 0, 1);
    check("rehome_done_edge", hd_rise_t - rel, (MT + 1) * HP + PL);
    check("exp_q_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/floppy_stepper.md
# floppy_stepper

Per-drive step generator that turns a note setpoint and enable into floppy-drive step/direction signals, so the head stepper motor sounds the note. It sits directly downstream of the register controller: one instance per drive, fed by that drive's 22-bit setpoint and enable outputs. Its `step_n` and `dir` outputs go to the drive connector. After reset it homes the head to track 0. It then bounces the head between track 0 and `MAX_TRACK` while a note plays.

## Interface
- `SP_WIDTH`, default 22: setpoint width, in clk cycles per step.
- `MAX_TRACK`, default 79: highest track index (≤127).
- `PULSE_LEN`, default 16: `step_n` low time, in clk cycles.
- `HOME_PERIOD`, default 150000: clk cycles between homing steps (must be > `PULSE_LEN`).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `setpoint`  in  `SP_WIDTH`  step period in clk cycles.
- `enable`  in  1  note on.
- `step_n`  out  1  active-low step pulse to drive.
- `dir`  out  1  1 = next step increments track, 0 = decrements.
- `track`  out  7  current head position.
- `home_done`  out  1  homing complete, note playback allowed.

## Operation
- FSM states: HOME, IDLE, PLAY.
- Reset values:
  - state HOME; `step_n`=1, `dir`=0, `track`=`MAX_TRACK`, `home_done`=0.
  - Period counter `cnt`=0; pulse counter idle.
- HOME:
  - Ignores `enable` and `setpoint`.
  - Launches `MAX_TRACK`+1 pulses, one every `HOME_PERIOD` cycles, with `dir`=0.
  - `track` decrements at each launch and saturates at 0.
  - When the last pulse ends (`step_n` returns high), goes to IDLE: `home_done`=1, `dir`=1.
- Valid setpoint: `setpoint` > `PULSE_LEN`. Anything ≤ `PULSE_LEN` (including 0) is silent.
- IDLE:
  - `cnt` held at 0.
  - Goes to PLAY when `enable`=1 and setpoint is valid.
- PLAY:
  - `cnt` increments every cycle.
  - When `cnt` ≥ `setpoint`−1: `cnt`←0 and a pulse launches.
  - Because the compare is ≥, shrinking `setpoint` mid-period fires on the next cycle.
  - Goes to IDLE when `enable`=0 or setpoint is invalid; `cnt` clears.
- Pulse launch:
  - `step_n` goes low for exactly `PULSE_LEN` cycles.
  - `track` updates at launch: +1 if `dir`=1, −1 if `dir`=0.
- Direction bounce, applied on the edge where `step_n` returns high:
  - `track`=`MAX_TRACK` → `dir`←0.
  - `track`=0 → `dir`←1.
  - `dir` never changes while `step_n` is low.
- A pulse in progress always completes, even if PLAY exits mid-pulse.
- `rst` mid-operation, including mid-pulse: all registers return to reset values. `step_n` is high the cycle after `rst` is sampled and homing restarts.
- Width rules:
  - `cnt` is `SP_WIDTH` bits and never wraps, since it clears at `setpoint`−1.
  - The homing counter is sized for `HOME_PERIOD`.
  - `track` is 7-bit unsigned, range 0..`MAX_TRACK`.

## Timing
- All outputs are registered.
- Edge E is the first edge that samples `enable`=1 in IDLE with a valid setpoint.
  - First `step_n` fall: edge E+`setpoint`+1.
  - Later falls: every `setpoint` edges.
  - `step_n` low time: `PULSE_LEN` cycles; high time: `setpoint`−`PULSE_LEN` cycles (≥1).
- `track` changes on the same edge that `step_n` falls.
- `dir` changes on the same edge that `step_n` rises.
- Homing:
  - First pulse falls `HOME_PERIOD` edges after reset is released.
  - Pulse spacing is `HOME_PERIOD`.
  - `home_done` rises on the edge that ends the last pulse.
- Latency from `enable` falling to no further launches: 1 cycle.

## Test plan
Parameters: `PULSE_LEN`=4, `HOME_PERIOD`=20, `MAX_TRACK`=7.
- Homing:
  - Stimulus: release `rst` with `enable`=1.
  - Response: 8 pulses, each 4 low cycles, spaced 20 cycles, `dir`=0; `track` goes 7→0.
  - `home_done` rises as the 8th pulse ends, with `dir`=1; no extra pulses while homing.
- Steady tone:
  - Stimulus: after homing, `setpoint`=10, `enable`=1 sampled at E.
  - Response: `step_n` falls at E+11, E+21, E+31, each low 4 cycles; `track` goes 1, 2, 3.
- Bounce:
  - Stimulus: continue the tone.
  - Response: after the launch with `track`=7, `dir` goes 0 at that pulse's end; the next launch gives `track`=6.
  - At `track`=0, `dir` goes 1 and the next launch gives `track`=1.
- Setpoint shrink:
  - Stimulus: `setpoint`=100 and PLAY; change to 10 when `cnt`=50.
  - Response: a pulse launches on the next cycle, then the period is 10.
- Silent and stop:
  - Stimulus: `setpoint`=4 with `enable`=1.
  - Response: no pulses, state stays IDLE.
  - Stimulus: with `setpoint`=10, drop `enable` one cycle after a fall.
  - Response: that pulse still lasts 4 cycles, and no further pulses follow.
- Reset mid-pulse:
  - Stimulus: assert `rst` during a low `step_n`.
  - Response: `step_n`=1 the next cycle, `track`=7, `home_done`=0, `dir`=0, and the homing sequence repeats.
